macc_chunk_sequencer: RTL and testbench

- Controller for the 1-to-n 8-bit MACC array. Each output pixel's dot product is split into NUM_CHUNKS input-channel chunks.
- On start, the block sequences the chunks into the array: it drives the chunk index to the weight/feature buffers, gates the array's i_valid from an upstream valid/ready handshake, and accumulates the NUM_MACC partial sums per chunk.
- When all chunks are summed, it presents the NUM_MACC final sums downstream under valid/ready.
- It sits between the line/weight buffers and the activation/quantisation stage of each conv layer.

---
 rtl/macc_chunk_sequencer.sv | 135 +++++++++++++
 tb/tb_macc_chunk_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/macc_chunk_sequencer.sv
// Chunk sequencer for the 1-to-n MACC array: issues NUM_CHUNKS beats, sums the per-lane
// partial results and hands the totals downstream. Optional MACC_CHUNK_SEQ_RELU_EN clamps negative lanes.

module macc_chunk_acc_lane #(
  parameter int DW = 20,
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] dout
);
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] ext;

  assign ext = AW'($signed(din));

  // First result of a pass overwrites instead of adding, so no separate clear cycle is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (en) acc <= (clr ? '0 : acc) + ext;
  end

`ifdef MACC_CHUNK_SEQ_RELU_EN
  assign dout = acc[AW-1] ? '0 : acc;
`else
  assign dout = acc;
`endif
endmodule

module macc_chunk_sequencer #(
  parameter  int NUM_MACC        = 5,
  parameter  int MACC_DATA_WIDTH = 20,
  parameter  int NUM_CHUNKS      = 4,
  localparam int CNT_WIDTH       = ($clog2(NUM_CHUNKS + 1) > 1) ? $clog2(NUM_CHUNKS + 1) : 1,
  localparam int ACC_WIDTH       = MACC_DATA_WIDTH + $clog2(NUM_CHUNKS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_WIDTH-1:0]            chunk_idx,
  input  logic                            feat_valid,
  output logic                            feat_ready,
  output logic                            macc_i_valid,
  input  logic [NUM_MACC*MACC_DATA_WIDTH-1:0] macc_o_data,
  input  logic                            macc_o_valid,
  output logic [NUM_MACC*ACC_WIDTH-1:0]   o_data,
  output logic                            o_valid,
  input  logic                            o_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   res_cnt;
  logic                   acc_en, acc_clr, beat, last_beat, res_done;

  logic [NUM_MACC-1:0][MACC_DATA_WIDTH-1:0] lane_in;
  logic [NUM_MACC-1:0][ACC_WIDTH-1:0]       lane_out;

  assign feat_ready   = (state == ISSUE);
  assign macc_i_valid = feat_valid & feat_ready;
  assign beat         = macc_i_valid;
  assign last_beat    = beat && (chunk_idx == CNT_WIDTH'(NUM_CHUNKS - 1));

  // Results can overlap issue, so accumulation runs in both ISSUE and DRAIN.
  assign acc_en   = macc_o_valid && ((state == ISSUE) || (state == DRAIN));
  assign acc_clr  = (res_cnt == '0);
  // Look ahead one result so o_valid rises on the edge that captures the final sum.
  assign res_done = (res_cnt == CNT_WIDTH'(NUM_CHUNKS)) ||
                    (acc_en && (res_cnt == CNT_WIDTH'(NUM_CHUNKS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      o_valid   <= 1'b0;
      chunk_idx <= '0;
      res_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (acc_en) res_cnt <= res_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          busy      <= 1'b1;
          chunk_idx <= '0;
          res_cnt   <= '0;
        end
        ISSUE: if (beat) begin
          if (last_beat) begin
            chunk_idx <= '0;
            if (res_done) begin
              state   <= OUTPUT;
              o_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            chunk_idx <= chunk_idx + 1'b1;
          end
        end
        DRAIN: if (res_done) begin
          state   <= OUTPUT;
          o_valid <= 1'b1;
        end
        OUTPUT: if (o_ready) begin
          state   <= IDLE;
          busy    <= 1'b0;
          o_valid <= 1'b0;
          done    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lane_in = macc_o_data;
  assign o_data  = lane_out;

  for (genvar k = 0; k < NUM_MACC; k++) begin : g_lane
    macc_chunk_acc_lane #(.DW(MACC_DATA_WIDTH), .AW(ACC_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (acc_en),
      .clr   (acc_clr),
      .din   (lane_in[k]),
      .dout  (lane_out[k])
    );
  end
endmodule

// File: tb/tb_macc_chunk_sequencer.sv
// Bench for macc_chunk_sequencer: table of chunk results run through a latency-6 array model,
// plus hand sequences for backpressure, stray results and mid-operation reset.

module tb_macc_chunk_sequencer;
  localparam int NM = 5, DW = 20, NC = 4, CW = 3, AW = 22, LAT = 6;

  logic clk, rst_n, start, busy, done, feat_valid, feat_ready, macc_i_valid;
  logic macc_o_valid, o_valid, o_ready;
  logic [CW-1:0]    chunk_idx;
  logic [NM*DW-1:0] macc_o_data;
  logic [NM*AW-1:0] o_data;

  macc_chunk_sequencer #(.NUM_MACC(NM), .MACC_DATA_WIDTH(DW), .NUM_CHUNKS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .chunk_idx(chunk_idx), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .macc_i_valid(macc_i_valid), .macc_o_data(macc_o_data), .macc_o_valid(macc_o_valid),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: fixed latency, not reset, so in-flight beats still emerge after a reset.
  logic [LAT-1:0]          pv = '0;
  logic [LAT-1:0][CW-1:0]  pidx = '0;
  logic [3:0][DW-1:0]      cl0, cl4, clm;
  logic                    inj_v;
  logic [DW-1:0]           inj_val;

  always @(posedge clk) begin
    pv   <= {pv[LAT-2:0], macc_i_valid};
    pidx <= {pidx[LAT-2:0], chunk_idx};
  end

  always_comb begin
    macc_o_data  = '0;
    macc_o_valid = pv[LAT-1] | inj_v;
    for (int k = 0; k < NM; k++) begin
      if (inj_v)       macc_o_data[k*DW +: DW] = inj_val;
      else if (k == 0) macc_o_data[k*DW +: DW] = cl0[pidx[LAT-1][1:0]];
      else if (k == 4) macc_o_data[k*DW +: DW] = cl4[pidx[LAT-1][1:0]];
      else             macc_o_data[k*DW +: DW] = clm[pidx[LAT-1][1:0]];
    end
  end

  typedef struct {
    logic [3:0][DW-1:0] l0, l4, lm;
    logic [15:0]        fv;
    int                 e0, e4, em;
  } vec_t;

  vec_t tv[6];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][DW-1:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][DW-1:0] r;
    r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_lane(input int e);
    logic [AW-1:0] r;
    r = AW'(e);
`ifdef MACC_CHUNK_SEQ_RELU_EN
    if (e < 0) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [AW-1:0] lane(input int k);
    return o_data[k*AW +: AW];
  endfunction

  // Caller is at a negedge; returns at the negedge where done should be high.
  task automatic run_vec(input vec_t v, input int hold);
    int beats, movs, c4, cv;
    logic fv_now;
    logic [NM*AW-1:0] d0;
    cl0 = v.l0; cl4 = v.l4; clm = v.lm;
    o_ready = (hold == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0; movs = 0; c4 = -1; cv = -1;
    for (int cyc = 0; cyc < 200 && cv < 0; cyc++) begin
      fv_now = (cyc < 16) ? v.fv[cyc] : 1'b1;
      feat_valid = fv_now;
      #1;
      if (beats < NC) begin
        chk("feat_ready", 32'(feat_ready), 32'd1);
        chk("chunk_idx", 32'(chunk_idx), 32'(beats));
        chk("i_valid", 32'(macc_i_valid), 32'(fv_now));
      end else begin
        chk("drain_i_valid", 32'(macc_i_valid), 32'd0);
      end
      if (macc_i_valid) beats++;
      if (macc_o_valid) begin
        movs++;
        if (movs == NC) c4 = cyc;
      end
      if (o_valid) cv = cyc;
      if (cv < 0) @(negedge clk);
    end
    feat_valid = 1'b0;
    chk("latency", 32'(cv), 32'(c4 + 1));
    chk("lane0", 32'(lane(0)), 32'(exp_lane(v.e0)));
    for (int k = 1; k < 4; k++) chk("lane_mid", 32'(lane(k)), 32'(exp_lane(v.em)));
    chk("lane4", 32'(lane(4)), 32'(exp_lane(v.e4)));
    d0 = o_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = (h == 3);
      #1;
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data == d0), 32'd1);
      chk("hold_i_valid", 32'(macc_i_valid), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    if (hold > 0) begin
      @(negedge clk);
      start = 1'b0;
      o_ready = 1'b1;
    end
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(o_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] l0_prev;
    tv[0] = '{l0: mk(100, -50, 7, 3), l4: mk(-1, -1, -1, -1), lm: mk(1, 2, 3, 4),
              fv: 16'hFFFF, e0: 60, e4: -4, em: 10};
    tv[1] = tv[0];
    tv[1].fv = 16'hFFE9;
    tv[2] = '{l0: mk(-524288, -524288, -524288, -524288), l4: mk(-524288, -524288, -524288, -524288),
              lm: mk(-524288, -524288, -524288, -524288), fv: 16'hFFFF,
              e0: -2097152, e4: -2097152, em: -2097152};
    tv[3] = '{l0: mk(-100, 50, -7, -3), l4: mk(30, 30, 0, 0), lm: mk(1, 2, 3, 4),
              fv: 16'hAAAA, e0: -60, e4: 60, em: 10};
    tv[4] = '{l0: mk(524287, 524287, 524287, 524287), l4: mk(0, 0, 0, 0), lm: mk(-7, 5, -3, 1),
              fv: 16'hFFFF, e0: 2097148, e4: 0, em: -4};
    tv[5] = '{l0: mk(1, 1, 1, 1), l4: mk(1, 1, 1, 1), lm: mk(1, 1, 1, 1),
              fv: 16'hFFFF, e0: 4, e4: 4, em: 4};

    rst_n = 1'b0; start = 1'b0; feat_valid = 1'b0; o_ready = 1'b0;
    inj_v = 1'b0; inj_val = '0;
    cl0 = '0; cl4 = '0; clm = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(feat_ready), 32'd0);
    chk("rst_idx", 32'(chunk_idx), 32'd0);
    chk("rst_data", 32'(o_data == '0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each next start lands in the same cycle as the previous done.
    for (int i = 0; i < 5; i++) run_vec(tv[i], 0);

    // Stray array result while idle must not touch the held sums.
    l0_prev = lane(0);
    inj_v = 1'b1; inj_val = 20'd1000;
    @(negedge clk);
    inj_v = 1'b0;
    #1;
    chk("idle_stray", 32'(lane(0)), 32'(l0_prev));

    // Downstream stall with an ignored start in the middle.
    @(negedge clk);
    run_vec(tv[0], 10);

    // Reset after two issued chunks; their late results arrive while idle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feat_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_idx", 32'(chunk_idx), 32'd0);
    chk("mid_rst_ready", 32'(feat_ready), 32'd0);
    chk("mid_rst_ivalid", 32'(macc_i_valid), 32'd0);
    chk("mid_rst_data", 32'(o_data == '0), 32'd1);
    feat_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("late_res_data", 32'(o_data == '0), 32'd1);
    chk("late_res_busy", 32'(busy), 32'd0);
    @(negedge clk);
    run_vec(tv[5], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
